// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, derivation helpers and
// the raw sync/active bundle carried down the latency line.
package vga_pkg;

    localparam int VGA640_H_FRONT = 16;
    localparam int VGA640_H_SYNC  = 96;
    localparam int VGA640_H_BACK  = 48;
    localparam int VGA640_H_ACT   = 640;
    localparam int VGA640_V_FRONT = 10;
    localparam int VGA640_V_SYNC  = 2;
    localparam int VGA640_V_BACK  = 33;
    localparam int VGA640_V_ACT   = 480;

    localparam int VGA800_H_FRONT = 40;
    localparam int VGA800_H_SYNC  = 128;
    localparam int VGA800_H_BACK  = 88;
    localparam int VGA800_H_ACT   = 800;
    localparam int VGA800_V_FRONT = 1;
    localparam int VGA800_V_SYNC  = 4;
    localparam int VGA800_V_BACK  = 23;
    localparam int VGA800_V_ACT   = 600;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } rawSync_t;

    function automatic int totalOf(input int front, input int sync,
                                   input int back, input int act);
        return front + sync + back + act;
    endfunction

    function automatic int blankOf(input int front, input int sync,
                                   input int back);
        return front + sync + back;
    endfunction

    // Counters reach TOTAL-1 and the address reaches ACT area-1.
    function automatic bit fitsCheck(input int hTot, input int vTot,
                                     input int hAct, input int vAct,
                                     input int cw, input int aw);
        longint cLim;
        longint aLim;
        cLim = longint'(1) << cw;
        aLim = longint'(1) << aw;
        return (hTot <= cLim) && (vTot <= cLim) &&
               (longint'(hAct) * longint'(vAct) <= aLim);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay: DEPTH-stage enabled shift line, W bits wide.
// DEPTH of zero degenerates to a plain wire.
module vga_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iEN,
    input  logic [W-1:0] iData,
    output logic [W-1:0] oData
);

    if (DEPTH == 0) begin : gPass
        logic unusedCtl;
        assign unusedCtl = &{1'b0, iCLK, iRST_N, iEN};
        assign oData = iData;
    end else begin : gShift
        logic [W-1:0] sr [DEPTH];

        // shift one stage per enabled cycle
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (iEN) begin
                sr[0] <= iData;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end

        assign oData = sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with host fetch
// interface and sync/blank delayed to match the host read latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_FRONT = VGA640_H_FRONT,
    parameter int   H_SYNC  = VGA640_H_SYNC,
    parameter int   H_BACK  = VGA640_H_BACK,
    parameter int   H_ACT   = VGA640_H_ACT,
    parameter int   V_FRONT = VGA640_V_FRONT,
    parameter int   V_SYNC  = VGA640_V_SYNC,
    parameter int   V_BACK  = VGA640_V_BACK,
    parameter int   V_ACT   = VGA640_V_ACT,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0,
    parameter int   PIX_LAT = 2,
    parameter int   CW      = 12,
    parameter int   AW      = 22
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iEN,
    input  logic [7:0]    iRed,
    input  logic [7:0]    iGreen,
    input  logic [7:0]    iBlue,
    output logic          oRequest,
    output logic [CW-1:0] oCurrent_X,
    output logic [CW-1:0] oCurrent_Y,
    output logic [AW-1:0] oAddress,
    output logic          oLine_Start,
    output logic          oFrame_Start,
    output logic [7:0]    oVGA_R,
    output logic [7:0]    oVGA_G,
    output logic [7:0]    oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_BLANK,
    output logic          oVGA_SYNC,
    output logic          oVGA_CLOCK
);

    localparam int H_TOTAL = totalOf(H_FRONT, H_SYNC, H_BACK, H_ACT);
    localparam int V_TOTAL = totalOf(V_FRONT, V_SYNC, V_BACK, V_ACT);
    localparam int H_BLANK = blankOf(H_FRONT, H_SYNC, H_BACK);
    localparam int V_BLANK = blankOf(V_FRONT, V_SYNC, V_BACK);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_BLK  = CW'(H_BLANK);
    localparam logic [CW-1:0] V_BLK  = CW'(V_BLANK);
    localparam logic [CW-1:0] H_SS   = CW'(H_FRONT);
    localparam logic [CW-1:0] H_SE   = CW'(H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_FRONT);
    localparam logic [CW-1:0] V_SE   = CW'(V_FRONT + V_SYNC);

    if (!fitsCheck(H_TOTAL, V_TOTAL, H_ACT, V_ACT, CW, AW)) begin : gSizeErr
        $error("vga_timing_gen: CW or AW too narrow for the timing");
    end

    if (PIX_LAT < 0 || PIX_LAT > 7) begin : gLatErr
        $error("vga_timing_gen: PIX_LAT out of range 0..7");
    end

    logic [CW-1:0] hCont;
    logic [CW-1:0] vCont;
    logic          hWrap;
    logic          vWrap;
    logic          active;
    rawSync_t      raw;
    rawSync_t      dly;

    assign hWrap  = (hCont == H_LAST);
    assign vWrap  = (vCont == V_LAST);
    assign active = (hCont >= H_BLK) && (vCont >= V_BLK);

    // raster counters, V steps on the H wrap edge
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCont <= '0;
            vCont <= '0;
        end else if (iEN) begin
            hCont <= hWrap ? '0 : hCont + CW'(1);
            if (hWrap) vCont <= vWrap ? '0 : vCont + CW'(1);
        end
    end

    assign oRequest     = active && iEN;
    assign oCurrent_X   = active ? hCont - H_BLK : '0;
    assign oCurrent_Y   = active ? vCont - V_BLK : '0;
    assign oLine_Start  = oRequest && (hCont == H_BLK);
    assign oFrame_Start = oLine_Start && (vCont == V_BLK);

    // linear address accumulator, restarts with each frame
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oAddress <= '0;
        end else if (iEN) begin
            if (hWrap && vWrap) oAddress <= '0;
            else if (active)    oAddress <= oAddress + AW'(1);
        end
    end

    assign raw.hs  = (hCont >= H_SS) && (hCont < H_SE);
    assign raw.vs  = (vCont >= V_SS) && (vCont < V_SE);
    assign raw.act = active;

    vga_pipe_delay #(
        .DEPTH (PIX_LAT),
        .W     ($bits(rawSync_t))
    ) uDelay (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (iEN),
        .iData  (raw),
        .oData  (dly)
    );

    // output register: polarity, blanking and video masking
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_HS    <= ~HS_POL;
            oVGA_VS    <= ~VS_POL;
            oVGA_BLANK <= 1'b0;
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
        end else if (iEN) begin
            oVGA_HS    <= dly.hs ? HS_POL : ~HS_POL;
            oVGA_VS    <= dly.vs ? VS_POL : ~VS_POL;
            oVGA_BLANK <= dly.act;
            oVGA_R     <= dly.act ? iRed   : '0;
            oVGA_G     <= dly.act ? iGreen : '0;
            oVGA_B     <= dly.act ? iBlue  : '0;
        end
    end

    assign oVGA_SYNC  = 1'b1;
    assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced raster, one
// latency-2 active-low instance and one latency-0 active-high one.
module tb_vga_timing_gen;

    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HBK = 2;
    localparam int HA  = 8;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VBK = 1;
    localparam int VA  = 4;
    localparam int CW  = 5;
    localparam int AW  = 6;
    localparam int HT  = HF + HSY + HBK + HA;
    localparam int VT  = VF + VSY + VBK + VA;
    localparam int HBL = HF + HSY + HBK;
    localparam int VBL = VF + VSY + VBK;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vid_t;

    typedef struct packed {
        logic       v;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } host_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic [7:0]    r1, g1, b1, r2, g2, b2;
    logic          req1, ls1, fs1, hs1, vs1, bl1, sy1, ck1;
    logic          req2, ls2, fs2, hs2, vs2, bl2, sy2, ck2;
    logic [CW-1:0] x1, y1, x2, y2;
    logic [AW-1:0] ad1, ad2;
    logic [7:0]    vr1, vg1, vb1, vr2, vg2, vb2;

    int    checks = 0;
    int    errors = 0;
    int    t = 0;
    host_t p1, p2, cur;
    vid_t  q1[$];
    vid_t  q2[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK), .V_ACT(VA),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .CW(CW), .AW(AW)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .iEN(en),
        .iRed(r1), .iGreen(g1), .iBlue(b1),
        .oRequest(req1), .oCurrent_X(x1), .oCurrent_Y(y1),
        .oAddress(ad1), .oLine_Start(ls1), .oFrame_Start(fs1),
        .oVGA_R(vr1), .oVGA_G(vg1), .oVGA_B(vb1),
        .oVGA_HS(hs1), .oVGA_VS(vs1), .oVGA_BLANK(bl1),
        .oVGA_SYNC(sy1), .oVGA_CLOCK(ck1)
    );

    vga_timing_gen #(
        .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK), .V_ACT(VA),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0), .CW(CW), .AW(AW)
    ) dut2 (
        .iCLK(clk), .iRST_N(rst_n), .iEN(en),
        .iRed(r2), .iGreen(g2), .iBlue(b2),
        .oRequest(req2), .oCurrent_X(x2), .oCurrent_Y(y2),
        .oAddress(ad2), .oLine_Start(ls2), .oFrame_Start(fs2),
        .oVGA_R(vr2), .oVGA_G(vg2), .oVGA_B(vb2),
        .oVGA_HS(hs2), .oVGA_VS(vs2), .oVGA_BLANK(bl2),
        .oVGA_SYNC(sy2), .oVGA_CLOCK(ck2)
    );

    // host with two-cycle latency; garbage when not requested
    assign r1 = p2.v ? p2.r : 8'hA5;
    assign g1 = p2.v ? p2.g : 8'h5A;
    assign b1 = p2.v ? p2.b : 8'hC3;
    // zero-latency host
    assign r2 = req2 ? {3'b0, x2} : 8'hA5;
    assign g2 = req2 ? {3'b0, y2} : 8'h5A;
    assign b2 = req2 ? (8'h3C ^ {3'b0, x2}) : 8'hC3;

    task automatic reset_model();
        vid_t i1;
        vid_t i2;
        t  = 0;
        p1 = '0;
        p2 = '0;
        q1.delete();
        q2.delete();
        i1 = '0;
        i1.hs = 1'b1;
        i1.vs = 1'b1;
        i2 = '0;
        repeat (3) q1.push_back(i1);
        q2.push_back(i2);
    endtask

    // compare one sampled cycle of both DUTs against the model
    task automatic score(input bit e);
        int   hc, vc, x, y;
        bit   act, er, el, ef;
        vid_t ex1, ex2;
        vid_t ob1, ob2;
        hc  = t % HT;
        vc  = t / HT;
        act = (hc >= HBL) && (vc >= VBL);
        x   = act ? hc - HBL : 0;
        y   = act ? vc - VBL : 0;
        er  = act && e;
        el  = er && (x == 0);
        ef  = el && (y == 0);
        cur.v = req1;
        cur.r = {3'b0, x1};
        cur.g = {3'b0, y1};
        cur.b = 8'h3C ^ {3'b0, x1};

        checks++;
        if ({req1, ls1, fs1, x1, y1} !== {er, el, ef, CW'(x), CW'(y)}) begin
            $display("FAIL ctl1 t=%0d got %b%b%b x%0d y%0d exp %b%b%b x%0d y%0d",
                     t, req1, ls1, fs1, x1, y1, er, el, ef, x, y);
            errors++;
        end
        checks++;
        if ({req2, ls2, fs2, x2, y2} !== {er, el, ef, CW'(x), CW'(y)}) begin
            $display("FAIL ctl2 t=%0d got %b%b%b x%0d y%0d exp %b%b%b x%0d y%0d",
                     t, req2, ls2, fs2, x2, y2, er, el, ef, x, y);
            errors++;
        end
        if (act) begin
            checks++;
            if (ad1 !== AW'(y * HA + x) || ad2 !== AW'(y * HA + x)) begin
                $display("FAIL addr t=%0d got %0d/%0d exp %0d",
                         t, ad1, ad2, y * HA + x);
                errors++;
            end
        end

        ob1 = {hs1, vs1, bl1, vr1, vg1, vb1};
        ob2 = {hs2, vs2, bl2, vr2, vg2, vb2};
        checks++;
        if (ob1 !== q1[0]) begin
            $display("FAIL video1 t=%0d got %h exp %h", t, ob1, q1[0]);
            errors++;
        end
        checks++;
        if (ob2 !== q2[0]) begin
            $display("FAIL video2 t=%0d got %h exp %h", t, ob2, q2[0]);
            errors++;
        end

        if (e) begin
            ex2.hs    = (hc >= HF) && (hc < HF + HSY);
            ex2.vs    = (vc >= VF) && (vc < VF + VSY);
            ex2.blank = act;
            ex2.r     = act ? 8'(x) : 8'h00;
            ex2.g     = act ? 8'(y) : 8'h00;
            ex2.b     = act ? (8'h3C ^ 8'(x)) : 8'h00;
            ex1       = ex2;
            ex1.hs    = ~ex2.hs;
            ex1.vs    = ~ex2.vs;
            void'(q1.pop_front());
            void'(q2.pop_front());
            q1.push_back(ex1);
            q2.push_back(ex2);
        end
    endtask

    task automatic cyc(input bit e);
        en = e;
        @(negedge clk);
        score(e);
        @(posedge clk);
        #1;
        if (e) begin
            p2 = p1;
            p1 = cur;
            t  = (t + 1) % FT;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req1, ls1, fs1, x1, y1, ad1, vr1, vg1, vb1, hs1, vs1, bl1, sy1, ck1}
            !== {3'b000, 10'd0, 6'd0, 24'd0, 5'b11011}) begin
            $display("FAIL reset1 got %b %b %b x%0d y%0d a%0d rgb %h%h%h %b%b%b%b%b",
                     req1, ls1, fs1, x1, y1, ad1, vr1, vg1, vb1,
                     hs1, vs1, bl1, sy1, ck1);
            errors++;
        end
        checks++;
        if ({req2, ls2, fs2, x2, y2, ad2, vr2, vg2, vb2, hs2, vs2, bl2, sy2, ck2}
            !== {3'b000, 10'd0, 6'd0, 24'd0, 5'b00011}) begin
            $display("FAIL reset2 got %b %b %b x%0d y%0d a%0d rgb %h%h%h %b%b%b%b%b",
                     req2, ls2, fs2, x2, y2, ad2, vr2, vg2, vb2,
                     hs2, vs2, bl2, sy2, ck2);
            errors++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_frame();
        int  blank1, hsLow1, hsFall1, vsHi2, blank2;
        logic prevHs;
        repeat (FT + 7) cyc(1'b1);
        blank1 = 0; hsLow1 = 0; hsFall1 = 0; vsHi2 = 0; blank2 = 0;
        prevHs = hs1;
        repeat (FT) begin
            cyc(1'b1);
            blank1 += int'(bl1);
            blank2 += int'(bl2);
            hsLow1 += int'(!hs1);
            hsFall1 += int'(prevHs && !hs1);
            vsHi2  += int'(vs2);
            prevHs = hs1;
        end
        checks++;
        if (blank1 != HA * VA || blank2 != HA * VA) begin
            $display("FAIL blank_count got %0d/%0d exp %0d", blank1, blank2, HA * VA);
            errors++;
        end
        checks++;
        if (hsLow1 != HSY * VT || hsFall1 != VT) begin
            $display("FAIL hs_shape got low %0d falls %0d exp %0d %0d",
                     hsLow1, hsFall1, HSY * VT, VT);
            errors++;
        end
        checks++;
        if (vsHi2 != VSY * HT) begin
            $display("FAIL vs2_width got %0d exp %0d", vsHi2, VSY * HT);
            errors++;
        end
    endtask

    task automatic test_enable_toggle();
        repeat (2 * FT) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    task automatic test_random_enable();
        repeat (400) cyc(1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_midline();
        int k;
        bit found;
        k = 0;
        while (t != (VBL + 2) * HT + HBL + 4 && k < 2 * FT) begin
            cyc(1'b1);
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req1, x1, y1, ad1, vr1, vg1, vb1, hs1, vs1, bl1}
            !== {1'b0, 10'd0, 6'd0, 24'd0, 3'b110}) begin
            $display("FAIL midreset1 got %b x%0d y%0d a%0d rgb %h%h%h %b%b%b",
                     req1, x1, y1, ad1, vr1, vg1, vb1, hs1, vs1, bl1);
            errors++;
        end
        checks++;
        if ({req2, x2, y2, ad2, vr2, vg2, vb2, hs2, vs2, bl2}
            !== {1'b0, 10'd0, 6'd0, 24'd0, 3'b000}) begin
            $display("FAIL midreset2 got %b x%0d y%0d a%0d rgb %h%h%h %b%b%b",
                     req2, x2, y2, ad2, vr2, vg2, vb2, hs2, vs2, bl2);
            errors++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        en    = 1'b1;
        k     = 0;
        found = 1'b0;
        while (!found && k < FT + 10) begin
            @(negedge clk);
            if (fs1 === 1'b1) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        checks++;
        if (!found || k != VBL * HT + HBL || fs2 !== 1'b1 || ad1 !== '0) begin
            $display("FAIL restart found=%0d k=%0d exp %0d fs2=%b addr=%0d",
                     found, k, VBL * HT + HBL, fs2, ad1);
            errors++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        p1    = '0;
        p2    = '0;
        cur   = '0;
        test_reset();
        test_frame();
        test_enable_toggle();
        test_random_enable();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
